// File: rtl/loader_pkg.sv
// Shared types and sizing for the program loader: FSM states, address/length widths.
package loader_pkg;

  localparam int ADDR_W    = 12;
  localparam int MAX_WORDS = 1024;
  localparam int LEN_W     = 11;
  localparam int PM_ADDR_W = ADDR_W;
  localparam int PM_DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WRITE,
    CHECK,
    DONE
  } state_t;

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and program-memory write port of the loader.
// The master drives bytes and watches the memory writes; the slave is the loader.
interface program_loader_if #(
  parameter int ADDR_W = loader_pkg::PM_ADDR_W
);
  logic                             byte_valid;
  logic [7:0]                       byte_data;
  logic                             byte_ready;
  logic                             pm_we;
  logic [ADDR_W-1:0]                pm_addr;
  logic [loader_pkg::PM_DATA_W-1:0] pm_wdata;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, pm_we, pm_addr, pm_wdata
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, pm_we, pm_addr, pm_wdata
  );
endinterface

// File: rtl/byte_packer.sv
// Collects four bytes little-endian into a 32-bit word; word_valid fires
// combinationally on the 4th accepted byte so the word can be registered that edge.
module byte_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        shift,
  input  logic [7:0]  data,
  output logic        word_valid,
  output logic [31:0] word
);
  logic [1:0]  idx;
  logic [23:0] low_bytes;

  // NOTE: the holding register is reset along with idx; it is a few flops, not a memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= 2'd0;
      low_bytes <= 24'd0;
    end else if (clear) begin
      idx <= 2'd0;
    end else if (shift) begin
      idx <= idx + 2'd1;
      case (idx)
        2'd0:    low_bytes[7:0]   <= data;
        2'd1:    low_bytes[15:8]  <= data;
        2'd2:    low_bytes[23:16] <= data;
        default: ;
      endcase
    end
  end

  assign word_valid = shift && (idx == 2'd3);
  assign word       = {data, low_bytes};

endmodule

// File: rtl/program_loader.sv
// Boot-time program loader: streams bytes into program memory and holds the core
// in reset until a good image is in. Define LOADER_CHECKSUM_EN for a trailing XOR checksum byte.
module program_loader #(
  parameter int ADDR_W    = loader_pkg::ADDR_W,
  parameter int MAX_WORDS = loader_pkg::MAX_WORDS
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [loader_pkg::LEN_W-1:0] len_words,
  program_loader_if.slave              bus,
  output logic                         core_rst_n,
  output logic                         busy,
  output logic                         done,
  output logic                         error
);
  import loader_pkg::*;

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_WORDS);

  state_t           state;
  logic [LEN_W-1:0] word_cnt;
  logic [LEN_W-1:0] len;
  logic             hs;
  logic             word_valid;
  logic [31:0]      word;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]       csum;
`endif

  assign hs = bus.byte_valid && bus.byte_ready;

  byte_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (start && (state == IDLE || state == DONE)),
    .shift      (hs && state == LOAD),
    .data       (bus.byte_data),
    .word_valid (word_valid),
    .word       (word)
  );

  // NOTE: all state and registered outputs use <= so every branch sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      word_cnt       <= '0;
      len            <= '0;
      bus.byte_ready <= 1'b0;
      bus.pm_we      <= 1'b0;
      bus.pm_addr    <= '0;
      bus.pm_wdata   <= '0;
      core_rst_n     <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum           <= 8'd0;
`endif
    end else begin
      bus.pm_we <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            if (len_words == '0) begin
              state      <= DONE;
              done       <= 1'b1;
              error      <= 1'b0;
              core_rst_n <= 1'b1;
            end else if (len_words > MAX_LEN) begin
              state      <= DONE;
              done       <= 1'b1;
              error      <= 1'b1;
              core_rst_n <= 1'b0;
            end else begin
              state          <= LOAD;
              len            <= len_words;
              word_cnt       <= '0;
              bus.pm_addr    <= '0;
              bus.byte_ready <= 1'b1;
              busy           <= 1'b1;
              done           <= 1'b0;
              error          <= 1'b0;
              core_rst_n     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
              csum           <= 8'd0;
`endif
            end
          end
        end

        LOAD: begin
`ifdef LOADER_CHECKSUM_EN
          if (hs) csum <= csum ^ bus.byte_data;
`endif
          if (word_valid) begin
            state          <= WRITE;
            bus.byte_ready <= 1'b0;
            bus.pm_we      <= 1'b1;
            bus.pm_wdata   <= word;
          end
        end

        WRITE: begin
          word_cnt <= word_cnt + LEN_W'(1);
          // The address only advances toward a word still to come, so a full-size
          // image leaves pm_addr on its last word instead of wrapping to zero.
          if (word_cnt + LEN_W'(1) < len) begin
            state          <= LOAD;
            bus.byte_ready <= 1'b1;
            bus.pm_addr    <= bus.pm_addr + ADDR_W'(4);
          end else begin
`ifdef LOADER_CHECKSUM_EN
            state          <= CHECK;
            bus.byte_ready <= 1'b1;
`else
            state          <= DONE;
            busy           <= 1'b0;
            done           <= 1'b1;
            error          <= 1'b0;
            core_rst_n     <= 1'b1;
`endif
          end
        end

`ifdef LOADER_CHECKSUM_EN
        CHECK: begin
          if (hs) begin
            state          <= DONE;
            bus.byte_ready <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b1;
            error          <= (bus.byte_data != csum);
            core_rst_n     <= (bus.byte_data == csum);
          end
        end
`endif

        default: state <= IDLE;
      endcase
    end
  end

endmodule
